s386_resp_compactor: RTL and testbench

S386_RESP_COMPACTOR -- requirements
Module: s386_resp_compactor

---
 rtl/s386_resp_pkg.sv | 17 +
 rtl/s386_misr.sv | 36 +++
 rtl/s386_resp_compactor.sv | 95 +++++++++
 tb/tb_s386_resp_compactor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/s386_resp_pkg.sv
// Shared state encoding and default constants for the s386 response compactor.
// Imported by the compactor top and its MISR stage.
package s386_resp_pkg;

    localparam int          DEF_N_IN  = 7;
    localparam int          DEF_SIG_W = 16;
    localparam int          DEF_CNT_W = 16;
    localparam logic [15:0] DEF_POLY  = 16'h1021;
    localparam logic [15:0] DEF_SEED  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/s386_misr.sv
// Multiple-input signature register: shift-left with polynomial feedback,
// folding the zero-extended response vector into the low bits on each enable.
module s386_misr
    import s386_resp_pkg::*;
#(
    parameter int               SIG_W = DEF_SIG_W,
    parameter int               N_IN  = DEF_N_IN,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [N_IN-1:0]  resp,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_next;

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
    end

    // Load has priority so a new run always starts from the seed.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/s386_resp_compactor.sv
// Compacts a run of len s386 response vectors into a MISR signature,
// with an IDLE/RUN/DONE controller, accepted-vector counter and len latch.
module s386_resp_compactor
    import s386_resp_pkg::*;
#(
    parameter int               N_IN  = DEF_N_IN,
    parameter int               SIG_W = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
    parameter int               CNT_W = DEF_CNT_W
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             resp_valid,
    input  logic [N_IN-1:0]  resp,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] count
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] len_q;
    logic             load_seed;
    logic             accept;
    logic             last;

    assign accept = resp_valid & resp_ready;
    assign last   = (count == (len_q - CNT_W'(1)));

    always_comb begin
        state_next = state;
        load_seed  = 1'b0;
        busy       = 1'b0;
        resp_ready = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_seed  = 1'b1;
                    state_next = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy       = 1'b1;
                resp_ready = 1'b1;
                if (resp_valid && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // len is only captured on an accepted start, so later changes cannot disturb a run.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            count <= '0;
            len_q <= '0;
        end else begin
            state <= state_next;
            if (load_seed) begin
                count <= '0;
                len_q <= len;
            end else if (accept) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    s386_misr #(
        .SIG_W (SIG_W),
        .N_IN  (N_IN),
        .POLY  (POLY)
    ) u_misr (
        .CK   (CK),
        .RST  (RST),
        .load (load_seed),
        .seed (SEED),
        .en   (accept),
        .resp (resp),
        .sig  (signature)
    );

endmodule

// File: tb/tb_s386_resp_compactor.sv
// Scoreboard bench for s386_resp_compactor: directed runs push expected
// signature/count, and a monitor pops and compares on every done pulse.
module tb_s386_resp_compactor;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        resp_valid = 1'b0;
    logic [6:0]  resp = '0;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [15:0] count;

    typedef struct packed {
        logic [15:0] sig;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;

    s386_resp_compactor dut (
        .CK         (CK),
        .RST        (RST),
        .start      (start),
        .len        (len),
        .resp_valid (resp_valid),
        .resp       (resp),
        .resp_ready (resp_ready),
        .busy       (busy),
        .done       (done),
        .signature  (signature),
        .count      (count)
    );

    always #5 CK = ~CK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge CK);
        #1;
    endtask

    // Pulse start for one edge; returns just after that edge.
    task automatic startRun(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        nextCycle();
        start = 1'b0;
    endtask

    // Present one valid vector for one edge; returns just after the accept edge.
    task automatic applyStimulus(input logic [6:0] v);
        resp_valid = 1'b1;
        resp       = v;
        nextCycle();
        resp_valid = 1'b0;
        resp       = '0;
    endtask

    // Monitor: every done cycle must match the oldest expected result.
    always @(negedge CK) begin
        if (!RST && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("done_signature", 32'(signature), 32'(e.sig));
                checkOutput("done_count", 32'(count), 32'(e.cnt));
            end
        end
    end

    initial begin
        // Reset state
        nextCycle();
        nextCycle();
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_ready", 32'(resp_ready), 0);
        checkOutput("rst_sig", 32'(signature), 0);
        checkOutput("rst_count", 32'(count), 0);
        RST = 1'b0;
        nextCycle();

        // Single vector run
        exp_q.push_back('{sig: 16'hEFDE, cnt: 16'd1});
        startRun(16'd1);
        checkOutput("run1_busy", 32'(busy), 1);
        checkOutput("run1_ready", 32'(resp_ready), 1);
        applyStimulus(7'h01);
        checkOutput("run1_done_lat", 32'(done), 1);
        checkOutput("run1_done_ready", 32'(resp_ready), 0);
        nextCycle();
        checkOutput("run1_done_fall", 32'(done), 0);
        checkOutput("run1_idle_busy", 32'(busy), 0);
        nextCycle();
        checkOutput("run1_sig_hold", 32'(signature), 32'h0000EFDE);

        // Two back-to-back vectors
        exp_q.push_back('{sig: 16'hCF9D, cnt: 16'd2});
        startRun(16'd2);
        applyStimulus(7'h01);
        checkOutput("run2_mid_done", 32'(done), 0);
        applyStimulus(7'h00);
        checkOutput("run2_done_lat", 32'(done), 1);
        nextCycle();
        nextCycle();

        // Two vectors with a three-cycle gap
        exp_q.push_back('{sig: 16'hCF9D, cnt: 16'd2});
        startRun(16'd2);
        applyStimulus(7'h01);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("gap_busy", 32'(busy), 1);
            checkOutput("gap_count", 32'(count), 1);
            checkOutput("gap_sig", 32'(signature), 32'h0000EFDE);
        end
        applyStimulus(7'h00);
        checkOutput("gap_done_lat", 32'(done), 1);
        nextCycle();
        nextCycle();

        // Zero-length run goes straight to DONE
        exp_q.push_back('{sig: 16'hFFFF, cnt: 16'd0});
        resp_valid = 1'b1;
        resp       = 7'h7F;
        checkOutput("len0_ready_pre", 32'(resp_ready), 0);
        startRun(16'd0);
        checkOutput("len0_done", 32'(done), 1);
        checkOutput("len0_ready_done", 32'(resp_ready), 0);
        nextCycle();
        checkOutput("len0_ready_after", 32'(resp_ready), 0);
        checkOutput("len0_busy_after", 32'(busy), 0);
        checkOutput("len0_count_after", 32'(count), 0);
        resp_valid = 1'b0;
        resp       = '0;
        nextCycle();

        // start and len changes during RUN are ignored
        exp_q.push_back('{sig: 16'hCF9D, cnt: 16'd2});
        startRun(16'd2);
        startRun(16'd5);
        checkOutput("restart_busy", 32'(busy), 1);
        checkOutput("restart_count", 32'(count), 0);
        applyStimulus(7'h01);
        applyStimulus(7'h00);
        checkOutput("restart_done_lat", 32'(done), 1);
        nextCycle();
        nextCycle();

        // Asynchronous reset mid-run abandons the run
        startRun(16'd3);
        applyStimulus(7'h01);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("arst_busy", 32'(busy), 0);
        checkOutput("arst_done", 32'(done), 0);
        checkOutput("arst_ready", 32'(resp_ready), 0);
        checkOutput("arst_sig", 32'(signature), 0);
        checkOutput("arst_count", 32'(count), 0);
        nextCycle();
        nextCycle();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
        end

        // Fresh run after reset behaves like the first run
        exp_q.push_back('{sig: 16'hEFDE, cnt: 16'd1});
        startRun(16'd1);
        applyStimulus(7'h01);
        checkOutput("post_rst_done_lat", 32'(done), 1);
        nextCycle();
        nextCycle();

        checkOutput("queue_empty", 32'(exp_q.size()), 0);
        checkOutput("done_pulses", 32'(done_seen), 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
